// File: rtl/dense_pkg.sv
// Shared definitions for the dense tile scheduler: FSM encoding, default
// geometry, legal config limits and a ceiling-divide helper.
package dense_pkg;

    localparam int unsigned DEF_NUM_COLS = 32;
    localparam int unsigned DEF_OC_W     = 10;
    localparam int unsigned DEF_IC_W     = 10;
    localparam int unsigned ARR_OC_W     = 8;
    localparam int unsigned K_MAX        = 3;
    localparam int unsigned STRIDE_MAX   = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT_LO = 3'd3,
        S_WAIT_HI = 3'd4,
        S_DRAIN   = 3'd5,
        S_FIN     = 3'd6
    } state_e;

    // Number of den-sized groups needed to cover num.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/dense_tile_counter.sv
// Nested OC-tile / input-channel counters with last-iteration flags.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_clear             zero both counters
//   i_ic_inc            advance input channel
//   i_tile_inc          advance OC tile and restart input channel at 0
//   i_cfg_oc, i_cfg_ic  captured layer sizes
//   o_oc_tile, o_ic     current counter values (registered)
//   o_oc_tile_nxt/o_ic_nxt  values the counters take at the next edge
//   o_ic_last, o_tile_last  current IC / tile is the final one
module dense_tile_counter
    import dense_pkg::*;
#(
    parameter int unsigned NUM_COLS = DEF_NUM_COLS,
    parameter int unsigned OC_W     = DEF_OC_W,
    parameter int unsigned IC_W     = DEF_IC_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clear,
    input  logic            i_ic_inc,
    input  logic            i_tile_inc,
    input  logic [OC_W-1:0] i_cfg_oc,
    input  logic [IC_W-1:0] i_cfg_ic,
    output logic [OC_W-1:0] o_oc_tile,
    output logic [IC_W-1:0] o_ic,
    output logic [OC_W-1:0] o_oc_tile_nxt,
    output logic [IC_W-1:0] o_ic_nxt,
    output logic            o_ic_last,
    output logic            o_tile_last
);

    logic [OC_W-1:0] r_oc_tile;
    logic [IC_W-1:0] r_ic;
    logic [OC_W-1:0] w_oc_tile_nxt;
    logic [IC_W-1:0] w_ic_nxt;
    logic [OC_W-1:0] w_n_tiles;

    // Next-value selection; clear has priority, tile advance restarts IC.
    always_comb begin
        w_oc_tile_nxt = r_oc_tile;
        w_ic_nxt      = r_ic;
        if (i_clear) begin
            w_oc_tile_nxt = '0;
            w_ic_nxt      = '0;
        end else if (i_tile_inc) begin
            w_oc_tile_nxt = r_oc_tile + OC_W'(1);
            w_ic_nxt      = '0;
        end else if (i_ic_inc) begin
            w_ic_nxt = r_ic + IC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_oc_tile <= '0;
            r_ic      <= '0;
        end else begin
            r_oc_tile <= w_oc_tile_nxt;
            r_ic      <= w_ic_nxt;
        end
    end

    assign w_n_tiles     = OC_W'(ceil_div(32'(i_cfg_oc), NUM_COLS));
    assign o_tile_last   = (r_oc_tile == (w_n_tiles - OC_W'(1)));
    assign o_ic_last     = (r_ic == (i_cfg_ic - IC_W'(1)));
    assign o_oc_tile     = r_oc_tile;
    assign o_ic          = r_ic;
    assign o_oc_tile_nxt = w_oc_tile_nxt;
    assign o_ic_nxt      = w_ic_nxt;

endmodule

// File: rtl/dense_tile_scheduler.sv
// Layer-level sequencer for dense_pe_array: walks OC tiles and input
// channels, handshaking row-mem load, array start/done and psum drain.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cfg_valid/cfg_ready, cfg_*       layer config handshake and fields
//   abort                            abandon the running layer
//   load_req/load_ack, load_oc_tile, load_ic   row-mem fill handshake
//   arr_start, arr_k/stride/img_w/oc/accum, arr_done   PE array control
//   drain_req/drain_ack              psum writeback handshake
//   layer_done, cfg_err              completion / rejection pulses
module dense_tile_scheduler
    import dense_pkg::*;
#(
    parameter int unsigned NUM_COLS = DEF_NUM_COLS,
    parameter int unsigned OC_W     = DEF_OC_W,
    parameter int unsigned IC_W     = DEF_IC_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_k,
    input  logic [2:0]          cfg_stride,
    input  logic [5:0]          cfg_img_h,
    input  logic [5:0]          cfg_img_w,
    input  logic [OC_W-1:0]     cfg_oc,
    input  logic [IC_W-1:0]     cfg_ic,
    input  logic                abort,
    output logic                load_req,
    output logic [OC_W-1:0]     load_oc_tile,
    output logic [IC_W-1:0]     load_ic,
    input  logic                load_ack,
    output logic                arr_start,
    output logic [2:0]          arr_k,
    output logic [2:0]          arr_stride,
    output logic [5:0]          arr_img_w,
    output logic [ARR_OC_W-1:0] arr_oc,
    output logic                arr_accum,
    input  logic                arr_done,
    output logic                drain_req,
    input  logic                drain_ack,
    output logic                layer_done,
    output logic                cfg_err
);

    state_e r_state, w_state_nxt;

    logic                r_cfg_ready, r_load_req, r_arr_start, r_drain_req;
    logic                r_layer_done, r_cfg_err, r_arr_accum;
    logic [2:0]          r_cfg_k, r_cfg_stride;
    logic [5:0]          r_cfg_img_w;
    logic [OC_W-1:0]     r_cfg_oc;
    logic [IC_W-1:0]     r_cfg_ic;
    logic [ARR_OC_W-1:0] r_arr_oc;

    logic                w_clear, w_ic_inc, w_tile_inc, w_cap, w_cfg_err_nxt, w_cfg_legal;
    logic                w_ic_last, w_tile_last;
    logic [OC_W-1:0]     w_oc_tile, w_oc_tile_nxt, w_oc_src, w_oc_rem;
    logic [IC_W-1:0]     w_ic, w_ic_nxt;
    logic [ARR_OC_W-1:0] w_arr_oc_nxt;

    // Image height is accepted for interface compatibility; the array does not consume it.
    logic w_unused_img_h;
    assign w_unused_img_h = ^cfg_img_h;

    dense_tile_counter #(
        .NUM_COLS (NUM_COLS),
        .OC_W     (OC_W),
        .IC_W     (IC_W)
    ) u_cnt (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_clear),
        .i_ic_inc      (w_ic_inc),
        .i_tile_inc    (w_tile_inc),
        .i_cfg_oc      (r_cfg_oc),
        .i_cfg_ic      (r_cfg_ic),
        .o_oc_tile     (w_oc_tile),
        .o_ic          (w_ic),
        .o_oc_tile_nxt (w_oc_tile_nxt),
        .o_ic_nxt      (w_ic_nxt),
        .o_ic_last     (w_ic_last),
        .o_tile_last   (w_tile_last)
    );

    assign w_cfg_legal = (cfg_k != 3'd0) && (cfg_k <= 3'(K_MAX)) &&
                         (cfg_stride != 3'd0) && (cfg_stride <= 3'(STRIDE_MAX)) &&
                         (cfg_oc != '0) && (cfg_ic != '0);

    // OCs left from the tile being entered; the config is still on the inputs when leaving IDLE.
    assign w_oc_src     = (r_state == S_IDLE) ? cfg_oc : r_cfg_oc;
    assign w_oc_rem     = w_oc_src - OC_W'(w_oc_tile_nxt * OC_W'(NUM_COLS));
    assign w_arr_oc_nxt = (w_oc_rem > OC_W'(NUM_COLS)) ? ARR_OC_W'(NUM_COLS) : ARR_OC_W'(w_oc_rem);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and counter control; abort overrides everything outside IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_clear       = 1'b0;
        w_ic_inc      = 1'b0;
        w_tile_inc    = 1'b0;
        w_cap         = 1'b0;
        w_cfg_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid && r_cfg_ready) begin
                    w_cap = 1'b1;
                    if (w_cfg_legal) begin
                        w_state_nxt = S_LOAD;
                        w_clear     = 1'b1;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
            end
            S_LOAD:    if (load_ack) w_state_nxt = S_START;
            S_START:   w_state_nxt = S_WAIT_LO;
            // Stale done from the previous run must fall before a rise counts.
            S_WAIT_LO: if (!arr_done) w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (arr_done) begin
                    if (w_ic_last) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_ic_inc    = 1'b1;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_ack) begin
                    if (w_tile_last) begin
                        w_clear     = 1'b1;
                        w_state_nxt = S_FIN;
                    end else begin
                        w_tile_inc  = 1'b1;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_clear     = 1'b1;
            w_ic_inc    = 1'b0;
            w_tile_inc  = 1'b0;
        end
    end

    // Registered outputs derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_ready  <= 1'b1;
            r_load_req   <= 1'b0;
            r_arr_start  <= 1'b0;
            r_drain_req  <= 1'b0;
            r_layer_done <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_arr_accum  <= 1'b0;
            r_arr_oc     <= '0;
            r_cfg_k      <= '0;
            r_cfg_stride <= '0;
            r_cfg_img_w  <= '0;
            r_cfg_oc     <= '0;
            r_cfg_ic     <= '0;
        end else begin
            r_cfg_ready  <= (w_state_nxt == S_IDLE);
            r_load_req   <= (w_state_nxt == S_LOAD);
            r_arr_start  <= (w_state_nxt == S_START);
            r_drain_req  <= (w_state_nxt == S_DRAIN);
            r_layer_done <= (w_state_nxt == S_FIN);
            r_cfg_err    <= w_cfg_err_nxt;
            if (w_cap) begin
                r_cfg_k      <= cfg_k;
                r_cfg_stride <= cfg_stride;
                r_cfg_img_w  <= cfg_img_w;
                r_cfg_oc     <= cfg_oc;
                r_cfg_ic     <= cfg_ic;
            end
            // Array config settles on LOAD entry and holds until the step completes.
            if (w_state_nxt == S_LOAD) begin
                r_arr_oc    <= w_arr_oc_nxt;
                r_arr_accum <= (w_ic_nxt != '0);
            end
        end
    end

    assign cfg_ready    = r_cfg_ready;
    assign load_req     = r_load_req;
    assign load_oc_tile = w_oc_tile;
    assign load_ic      = w_ic;
    assign arr_start    = r_arr_start;
    assign arr_k        = r_cfg_k;
    assign arr_stride   = r_cfg_stride;
    assign arr_img_w    = r_cfg_img_w;
    assign arr_oc       = r_arr_oc;
    assign arr_accum    = r_arr_accum;
    assign drain_req    = r_drain_req;
    assign layer_done   = r_layer_done;
    assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_dense_tile_scheduler.sv
// Scoreboard bench for dense_tile_scheduler: stimulus queues expected events,
// a negedge monitor pops and compares whenever the DUT emits one.
module tb_dense_tile_scheduler;

    localparam logic [2:0] EV_LOAD = 3'd1, EV_START = 3'd2, EV_DRAIN = 3'd3,
                           EV_DONE = 3'd4, EV_ERR = 3'd5;

    typedef struct packed {
        logic [2:0] kind;
        logic [9:0] oc_tile;
        logic [9:0] ic;
        logic [7:0] oc;
        logic       acc;
        logic [2:0] k;
        logic [2:0] s;
        logic [5:0] w;
    } ev_t;

    logic       clk, reset, cfg_valid, cfg_ready, abort;
    logic [2:0] cfg_k, cfg_stride;
    logic [5:0] cfg_img_h, cfg_img_w;
    logic [9:0] cfg_oc, cfg_ic;
    logic       load_req, load_ack, arr_start, arr_accum, arr_done;
    logic [9:0] load_oc_tile, load_ic;
    logic [2:0] arr_k, arr_stride;
    logic [5:0] arr_img_w;
    logic [7:0] arr_oc;
    logic       drain_req, drain_ack, layer_done, cfg_err;

    ev_t  exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic auto_en, man_load_ack, man_done;
    logic [2:0] tk, ts;
    logic [5:0] tw;

    dense_tile_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_k        (cfg_k),
        .cfg_stride   (cfg_stride),
        .cfg_img_h    (cfg_img_h),
        .cfg_img_w    (cfg_img_w),
        .cfg_oc       (cfg_oc),
        .cfg_ic       (cfg_ic),
        .abort        (abort),
        .load_req     (load_req),
        .load_oc_tile (load_oc_tile),
        .load_ic      (load_ic),
        .load_ack     (load_ack),
        .arr_start    (arr_start),
        .arr_k        (arr_k),
        .arr_stride   (arr_stride),
        .arr_img_w    (arr_img_w),
        .arr_oc       (arr_oc),
        .arr_accum    (arr_accum),
        .arr_done     (arr_done),
        .drain_req    (drain_req),
        .drain_ack    (drain_ack),
        .layer_done   (layer_done),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic push(input logic [2:0] kind, input int tile, input int ic,
                        input int oc, input logic acc);
        ev_t e;
        e         = '0;
        e.kind    = kind;
        e.oc_tile = 10'(tile);
        if (kind == EV_LOAD || kind == EV_START) begin
            e.ic  = 10'(ic);
            e.oc  = 8'(oc);
            e.acc = acc;
            e.k   = tk;
            e.s   = ts;
            e.w   = tw;
        end
        exp_q.push_back(e);
    endtask

    task automatic send_cfg(input logic [2:0] k, input logic [2:0] s, input logic [5:0] w,
                            input logic [9:0] oc, input logic [9:0] ic);
        @(posedge clk); #1;
        cfg_k = k; cfg_stride = s; cfg_img_h = w; cfg_img_w = w;
        cfg_oc = oc; cfg_ic = ic; cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_q(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Responder: row-mem, PE array and writeback models (auto) or bench-driven levels (manual).
    initial begin
        int ld, dr, ac;
        ld = 0; dr = 0; ac = 0;
        load_ack = 1'b0; drain_ack = 1'b0; arr_done = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (auto_en) begin
                ld = load_req ? ld + 1 : 0;
                load_ack = (ld == 2);
                dr = drain_req ? dr + 1 : 0;
                drain_ack = (dr == 3);
                if (arr_start) ac = 1;
                else if (ac != 0) ac++;
                if (ac == 3) arr_done = 1'b0;
                if (ac == 6) begin
                    arr_done = 1'b1;
                    ac = 0;
                end
            end else begin
                ld = 0; dr = 0; ac = 0;
                load_ack  = man_load_ack;
                drain_ack = 1'b0;
                arr_done  = man_done;
            end
        end
    end

    // Monitor: every emitted event is checked against the scoreboard head.
    logic p_load = 1'b0, p_drain = 1'b0, p_done = 1'b0, rose = 1'b0, pend = 1'b0;

    task automatic observe(input logic [2:0] kind);
        ev_t a, e;
        a         = '0;
        a.kind    = kind;
        a.oc_tile = (kind == EV_DONE || kind == EV_ERR) ? 10'd0 : load_oc_tile;
        if (kind == EV_LOAD || kind == EV_START) begin
            a.ic = load_ic; a.oc = arr_oc; a.acc = arr_accum;
            a.k = arr_k; a.s = arr_stride; a.w = arr_img_w;
        end
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 64'(a), 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("event", 64'(a), 64'(e));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (arr_done && !p_done) rose = 1'b1;
            if (cfg_ready) pend = 1'b0;
            if (load_req && !p_load) begin
                if (pend) chk("done_low_then_high", 64'(rose), 64'd1);
                pend = 1'b0;
                observe(EV_LOAD);
            end
            if (arr_start) begin
                rose = 1'b0;
                pend = 1'b1;
                observe(EV_START);
            end
            if (drain_req && !p_drain) begin
                if (pend) chk("done_low_then_high", 64'(rose), 64'd1);
                pend = 1'b0;
                observe(EV_DRAIN);
            end
            if (layer_done) observe(EV_DONE);
            if (cfg_err)    observe(EV_ERR);
            p_load  = load_req;
            p_drain = drain_req;
            p_done  = arr_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
        cfg_k = '0; cfg_stride = '0; cfg_img_h = '0; cfg_img_w = '0; cfg_oc = '0; cfg_ic = '0;
        auto_en = 1'b1; man_load_ack = 1'b0; man_done = 1'b0;
        tk = '0; ts = '0; tw = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", 64'({cfg_ready, load_req, arr_start, drain_req, layer_done, cfg_err, arr_accum}), 64'b1000000);
        chk("reset_data", 64'({arr_oc, load_oc_tile, load_ic, arr_k, arr_stride, arr_img_w}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single tile, single IC.
        tk = 3'd3; ts = 3'd1; tw = 6'd8;
        push(EV_LOAD, 0, 0, 32, 1'b0); push(EV_START, 0, 0, 32, 1'b0);
        push(EV_DRAIN, 0, 0, 0, 1'b0); push(EV_DONE, 0, 0, 0, 1'b0);
        send_cfg(3'd3, 3'd1, 6'd8, 10'd32, 10'd1);
        wait_q("t1");

        // Two tiles (32 + 8 OCs) x two ICs, with stale arr_done between runs.
        tk = 3'd1; ts = 3'd2; tw = 6'd16;
        for (int t = 0; t < 2; t++) begin
            for (int c = 0; c < 2; c++) begin
                push(EV_LOAD,  t, c, (t == 0) ? 32 : 8, c != 0);
                push(EV_START, t, c, (t == 0) ? 32 : 8, c != 0);
            end
            push(EV_DRAIN, t, 0, 0, 1'b0);
        end
        push(EV_DONE, 0, 0, 0, 1'b0);
        send_cfg(3'd1, 3'd2, 6'd16, 10'd40, 10'd2);
        wait_q("t2");

        // Illegal configs: k=0, oc=0, stride=4.
        push(EV_ERR, 0, 0, 0, 1'b0);
        send_cfg(3'd0, 3'd1, 6'd8, 10'd32, 10'd1);
        wait_q("err_k");
        @(negedge clk);
        chk("err_k_ready", 64'({cfg_ready, load_req}), 64'b10);
        push(EV_ERR, 0, 0, 0, 1'b0);
        send_cfg(3'd2, 3'd1, 6'd8, 10'd0, 10'd1);
        wait_q("err_oc");
        @(negedge clk);
        chk("err_oc_ready", 64'({cfg_ready, load_req}), 64'b10);
        push(EV_ERR, 0, 0, 0, 1'b0);
        send_cfg(3'd2, 3'd4, 6'd8, 10'd32, 10'd1);
        wait_q("err_s");

        // Abort in WAIT_HI while arr_done rises in the same cycle.
        tk = 3'd3; ts = 3'd1; tw = 6'd12;
        push(EV_LOAD, 0, 0, 32, 1'b0); push(EV_START, 0, 0, 32, 1'b0);
        @(posedge clk); #1;
        auto_en = 1'b0; man_done = 1'b1;
        send_cfg(3'd3, 3'd1, 6'd12, 10'd32, 10'd1);
        n = 0;
        while (!load_req && n < 50) begin @(posedge clk); #1; n++; end
        chk("abort_load_seen", 64'(load_req), 64'd1);
        man_load_ack = 1'b1;
        @(posedge clk); #1;
        man_load_ack = 1'b0;
        n = 0;
        while (!arr_start && n < 50) begin @(posedge clk); #1; n++; end
        chk("abort_start_seen", 64'(arr_start), 64'd1);
        man_done = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        man_done = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", 64'({cfg_ready, drain_req, layer_done, load_req}), 64'b1000);
        repeat (20) @(posedge clk);
        wait_q("abort");
        auto_en = 1'b1;

        // Reset while in DRAIN, then a clean three-tile layer.
        tk = 3'd2; ts = 3'd3; tw = 6'd10;
        push(EV_LOAD, 0, 0, 32, 1'b0); push(EV_START, 0, 0, 32, 1'b0);
        push(EV_DRAIN, 0, 0, 0, 1'b0);
        send_cfg(3'd2, 3'd3, 6'd10, 10'd64, 10'd1);
        n = 0;
        while (!drain_req && n < 200) begin @(posedge clk); #1; n++; end
        chk("rst_drain_seen", 64'(drain_req), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", 64'({cfg_ready, load_req, arr_start, drain_req, layer_done, cfg_err, arr_accum}), 64'b1000000);
        chk("rst_data", 64'({arr_oc, load_oc_tile, load_ic, arr_k, arr_stride, arr_img_w}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_q("rst");

        tk = 3'd2; ts = 3'd1; tw = 6'd20;
        for (int t = 0; t < 3; t++) begin
            push(EV_LOAD,  t, 0, (t == 2) ? 6 : 32, 1'b0);
            push(EV_START, t, 0, (t == 2) ? 6 : 32, 1'b0);
            push(EV_DRAIN, t, 0, 0, 1'b0);
        end
        push(EV_DONE, 0, 0, 0, 1'b0);
        send_cfg(3'd2, 3'd1, 6'd20, 10'd70, 10'd1);
        wait_q("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
